// File: rtl/ship_placer_pkg.sv
// Shared definitions for the ship placer: cell codes, grid size, ship lengths,
// FSM state encoding and the linear cell index helper.
package ship_placer_pkg;

  localparam int GRID_DIM = 10;

  typedef logic [1:0] cell_t;

  localparam cell_t EMPTY = 2'b00;
  localparam cell_t SHIP  = 2'b01;
  localparam cell_t MISS  = 2'b10;
  localparam cell_t HIT   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PICK,
    S_CHECK,
    S_WRITE,
    S_NEXT,
    S_DONE,
    S_FAIL
  } state_t;

  // Ship lengths by placement order; total 17 cells.
  function automatic logic [2:0] ship_len(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'd5;
      3'd1:    return 3'd4;
      3'd2:    return 3'd3;
      3'd3:    return 3'd3;
      default: return 3'd2;
    endcase
  endfunction

  // idx = row*10 + col, built from shifts.
  function automatic logic [6:0] cell_idx(input logic [3:0] row, input logic [3:0] col);
    return {row, 3'b000} + {2'b00, row, 1'b0} + {3'b000, col};
  endfunction

endpackage

// File: rtl/ship_placer_if.sv
// Board write bus and game status between the ship placer and its host.
interface ship_placer_if;
  import ship_placer_pkg::*;

  logic       start;
  logic       wr_en;
  logic [3:0] wr_row;
  logic [3:0] wr_col;
  cell_t      wr_data;
  logic       busy;
  logic       done;
  logic       fail;
  logic [2:0] ships_placed;

  modport master (
    input  start,
    output wr_en, wr_row, wr_col, wr_data, busy, done, fail, ships_placed
  );

  modport slave (
    output start,
    input  wr_en, wr_row, wr_col, wr_data, busy, done, fail, ships_placed
  );

endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, free running; reset loads seed.
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ship_placer.sv
// Clears a 10x10 board, then places NUM_SHIPS ships at pseudo-random positions
// without overlap, mirroring occupancy in a 100-bit shadow.
module ship_placer
  import ship_placer_pkg::*;
#(
  parameter int          NUM_SHIPS    = 5,
  parameter int          MAX_ATTEMPTS = 255,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  ship_placer_if.master bus
);

  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
  localparam logic [AW-1:0] MAX_A = AW'(MAX_ATTEMPTS);

  state_t        state_q, state_d;
  logic [3:0]    cur_row_q, cur_row_d;
  logic [3:0]    cur_col_q, cur_col_d;
  logic [3:0]    base_row_q, base_row_d;
  logic [3:0]    base_col_q, base_col_d;
  logic          horiz_q, horiz_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [2:0]    ships_q, ships_d;
  logic [AW-1:0] attempts_q, attempts_d;
  logic [99:0]   occ_q, occ_d;
  logic          wr_en_q, wr_en_d;
  logic [3:0]    wr_row_q, wr_row_d;
  logic [3:0]    wr_col_q, wr_col_d;
  cell_t         wr_data_q, wr_data_d;

  logic [15:0]   lfsr;
  logic [6:0]    lfsr_unused;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .seed  (LFSR_SEED),
    .q     (lfsr)
  );

  assign lfsr_unused = lfsr[15:9];

  logic [2:0]    len;
  logic [3:0]    pick_row, pick_col;
  logic          pick_h;
  logic [4:0]    pick_end;
  logic          pick_ok;
  logic [6:0]    cur_idx;
  logic          last_cell;
  logic [AW-1:0] attempts_inc;
  logic [3:0]    step_row, step_col;

  always_comb begin
    len       = ship_len(ships_q);
    pick_row  = lfsr[3:0];
    pick_col  = lfsr[7:4];
    pick_h    = lfsr[8];
    pick_end  = (pick_h ? {1'b0, pick_col} : {1'b0, pick_row}) + {2'b00, len} - 5'd1;
    pick_ok   = (pick_row <= 4'd9) && (pick_col <= 4'd9) && (pick_end <= 5'd9);
    cur_idx   = cell_idx(cur_row_q, cur_col_q);
    last_cell = (cnt_q == len - 3'd1);
    // Saturate so collisions after the budget is spent cannot wrap the counter.
    attempts_inc = (attempts_q >= MAX_A) ? attempts_q : attempts_q + 1'b1;
    step_row  = horiz_q ? cur_row_q : cur_row_q + 4'd1;
    step_col  = horiz_q ? cur_col_q + 4'd1 : cur_col_q;
  end

  always_comb begin
    state_d    = state_q;
    cur_row_d  = cur_row_q;
    cur_col_d  = cur_col_q;
    base_row_d = base_row_q;
    base_col_d = base_col_q;
    horiz_d    = horiz_q;
    cnt_d      = cnt_q;
    ships_d    = ships_q;
    attempts_d = attempts_q;
    occ_d      = occ_q;
    wr_en_d    = 1'b0;
    wr_row_d   = wr_row_q;
    wr_col_d   = wr_col_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (bus.start) begin
          state_d    = S_CLEAR;
          ships_d    = 3'd0;
          attempts_d = '0;
          occ_d      = '0;
          cur_row_d  = 4'd0;
          cur_col_d  = 4'd0;
        end
      end

      S_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_row_d  = cur_row_q;
        wr_col_d  = cur_col_q;
        wr_data_d = EMPTY;
        if (cur_col_q == 4'd9) begin
          cur_col_d = 4'd0;
          if (cur_row_q == 4'd9) begin
            state_d = S_PICK;
          end else begin
            cur_row_d = cur_row_q + 4'd1;
          end
        end else begin
          cur_col_d = cur_col_q + 4'd1;
        end
      end

      S_PICK: begin
        attempts_d = attempts_inc;
        if (pick_ok) begin
          base_row_d = pick_row;
          base_col_d = pick_col;
          cur_row_d  = pick_row;
          cur_col_d  = pick_col;
          horiz_d    = pick_h;
          cnt_d      = 3'd0;
          state_d    = S_CHECK;
        end else if (attempts_inc >= MAX_A) begin
          state_d = S_FAIL;
        end
      end

      S_CHECK: begin
        if (occ_q[cur_idx]) begin
          state_d = S_PICK;
        end else if (last_cell) begin
          cur_row_d = base_row_q;
          cur_col_d = base_col_q;
          cnt_d     = 3'd0;
          state_d   = S_WRITE;
        end else begin
          cur_row_d = step_row;
          cur_col_d = step_col;
          cnt_d     = cnt_q + 3'd1;
        end
      end

      S_WRITE: begin
        wr_en_d        = 1'b1;
        wr_row_d       = cur_row_q;
        wr_col_d       = cur_col_q;
        wr_data_d      = SHIP;
        occ_d[cur_idx] = 1'b1;
        if (last_cell) begin
          state_d = S_NEXT;
        end else begin
          cur_row_d = step_row;
          cur_col_d = step_col;
          cnt_d     = cnt_q + 3'd1;
        end
      end

      S_NEXT: begin
        ships_d = ships_q + 3'd1;
        state_d = (ships_q + 3'd1 == 3'(NUM_SHIPS)) ? S_DONE : S_PICK;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cur_row_q  <= 4'd0;
      cur_col_q  <= 4'd0;
      base_row_q <= 4'd0;
      base_col_q <= 4'd0;
      horiz_q    <= 1'b0;
      cnt_q      <= 3'd0;
      ships_q    <= 3'd0;
      attempts_q <= '0;
      occ_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_row_q   <= 4'd0;
      wr_col_q   <= 4'd0;
      wr_data_q  <= EMPTY;
    end else begin
      state_q    <= state_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      base_row_q <= base_row_d;
      base_col_q <= base_col_d;
      horiz_q    <= horiz_d;
      cnt_q      <= cnt_d;
      ships_q    <= ships_d;
      attempts_q <= attempts_d;
      occ_q      <= occ_d;
      wr_en_q    <= wr_en_d;
      wr_row_q   <= wr_row_d;
      wr_col_q   <= wr_col_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.wr_en        = wr_en_q;
  assign bus.wr_row       = wr_row_q;
  assign bus.wr_col       = wr_col_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.busy         = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAIL);
  assign bus.done         = (state_q == S_DONE);
  assign bus.fail         = (state_q == S_FAIL);
  assign bus.ships_placed = ships_q;

endmodule

// File: tb/tb_ship_placer.sv
// Bench for ship_placer: scenario table of whole games checked for board-write
// structure and status, plus hand-written reset-abort sequence.
module tb_ship_placer;
  import ship_placer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start_r;
  int   cur_sel;

  ship_placer_if bus0 ();
  ship_placer_if bus1 ();
  ship_placer_if bus2 ();

  assign bus0.start = start_r && (cur_sel == 0);
  assign bus1.start = start_r && (cur_sel == 1);
  assign bus2.start = start_r && (cur_sel == 2);

  ship_placer u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  ship_placer #(.LFSR_SEED(16'h1234)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  ship_placer #(.MAX_ATTEMPTS(5)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  logic       m_wr_en, m_busy, m_done, m_fail;
  logic [3:0] m_row, m_col;
  logic [1:0] m_data;
  logic [2:0] m_ships;

  always_comb begin
    m_wr_en = bus0.wr_en; m_row = bus0.wr_row; m_col = bus0.wr_col; m_data = bus0.wr_data;
    m_busy = bus0.busy; m_done = bus0.done; m_fail = bus0.fail; m_ships = bus0.ships_placed;
    if (cur_sel == 1) begin
      m_wr_en = bus1.wr_en; m_row = bus1.wr_row; m_col = bus1.wr_col; m_data = bus1.wr_data;
      m_busy = bus1.busy; m_done = bus1.done; m_fail = bus1.fail; m_ships = bus1.ships_placed;
    end else if (cur_sel == 2) begin
      m_wr_en = bus2.wr_en; m_row = bus2.wr_row; m_col = bus2.wr_col; m_data = bus2.wr_data;
      m_busy = bus2.busy; m_done = bus2.done; m_fail = bus2.fail; m_ships = bus2.ships_placed;
    end
  end

  int checks = 0;
  int errors = 0;

  int   len_tab [5] = '{5, 4, 3, 3, 2};
  logic [3:0] lg_row [256];
  logic [3:0] lg_col [256];
  logic [1:0] lg_data [256];
  int   lg_n;
  logic [3:0] ref_row [256];
  logic [3:0] ref_col [256];
  logic [1:0] ref_data [256];
  int   ref_n;
  bit   board [100];

  typedef struct {
    int sel;       // 0 default, 1 seed 1234, 2 MAX_ATTEMPTS=5
    int perturb;   // 0 none, 1 start pulses mid-CLEAR and mid-WRITE
    bit exp_done;
    bit exp_fail;
    int mode;      // 0 store ref, 1 equal ref, 2 differ from ref, 3 none
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // perturb 2: stop right after the third SHIP write appears, asserting reset.
  task automatic run_game(input int sel, input int perturb, input bit do_reset, output bit timed_out);
    int n_e, n_s;
    cur_sel = sel;
    start_r = 1'b0;
    lg_n = 0; n_e = 0; n_s = 0;
    timed_out = 1'b1;
    if (do_reset) begin
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 start_r = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk);
      #1;
      start_r = 1'b0;
      if (m_wr_en) begin
        if (lg_n < 256) begin
          lg_row[lg_n] = m_row; lg_col[lg_n] = m_col; lg_data[lg_n] = m_data;
        end
        lg_n++;
        if (m_data == EMPTY) n_e++;
        else n_s++;
        if (perturb == 1 && ((m_data == EMPTY && n_e == 50) || (m_data == SHIP && n_s == 2)))
          start_r = 1'b1;
        if (perturb == 2 && m_data == SHIP && n_s == 3) begin
          reset = 1'b1;
          timed_out = 1'b0;
          break;
        end
      end
      if (m_done || m_fail) begin
        timed_out = 1'b0;
        break;
      end
    end
    start_r = 1'b0;
  endtask

  task automatic verify_game(input string tag, input bit exp_done, input bit exp_fail);
    int n, n_e, n_s, bad, k, ship, len, idx, r0, c0, er, ec;
    bit h;
    n = (lg_n > 256) ? 256 : lg_n;
    n_e = 0; n_s = 0;
    for (int i = 0; i < n; i++) begin
      if (lg_data[i] == EMPTY) n_e++;
      else n_s++;
    end
    check({tag, "_empty_cnt"}, n_e, 100);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (i >= n) bad++;
      else if (lg_data[i] != EMPTY || int'(lg_row[i]) != i / 10 || int'(lg_col[i]) != i % 10) bad++;
    end
    check({tag, "_empty_order"}, bad, 0);

    for (int i = 0; i < 100; i++) board[i] = 1'b0;
    k = 100; ship = 0; bad = 0;
    while (k < n && ship < 5) begin
      len = len_tab[ship];
      if (k + len > n) begin
        bad++;
        break;
      end
      h  = (lg_row[k + 1] == lg_row[k]);
      r0 = int'(lg_row[k]);
      c0 = int'(lg_col[k]);
      for (int j = 0; j < len; j++) begin
        idx = k + j;
        er = h ? r0 : r0 + j;
        ec = h ? c0 + j : c0;
        if (lg_data[idx] != SHIP || int'(lg_row[idx]) != er || int'(lg_col[idx]) != ec
            || er > 9 || ec > 9) bad++;
        else if (board[er * 10 + ec]) bad++;
        else board[er * 10 + ec] = 1'b1;
      end
      k += len;
      ship++;
    end
    if (k != n) bad++;
    check({tag, "_ship_geom"}, bad, 0);
    if (exp_done) begin
      check({tag, "_ship_writes"}, n_s, 17);
      check({tag, "_ships_placed"}, m_ships, 5);
    end else begin
      check({tag, "_ships_placed"}, m_ships, ship);
    end
    check({tag, "_done"}, m_done, exp_done);
    check({tag, "_fail"}, m_fail, exp_fail);
    check({tag, "_busy"}, m_busy, 0);
  endtask

  task automatic diff_ref(output int diff);
    diff = (lg_n != ref_n) ? 1 : 0;
    for (int i = 0; i < 256; i++) begin
      if (i < lg_n && i < ref_n &&
          (lg_row[i] != ref_row[i] || lg_col[i] != ref_col[i] || lg_data[i] != ref_data[i]))
        diff++;
    end
  endtask

  initial begin
    bit to;
    int diff, bad;

    vecs[0] = '{sel: 0, perturb: 0, exp_done: 1'b1, exp_fail: 1'b0, mode: 0};
    vecs[1] = '{sel: 0, perturb: 0, exp_done: 1'b1, exp_fail: 1'b0, mode: 1};
    vecs[2] = '{sel: 0, perturb: 1, exp_done: 1'b1, exp_fail: 1'b0, mode: 1};
    vecs[3] = '{sel: 1, perturb: 0, exp_done: 1'b1, exp_fail: 1'b0, mode: 2};
    vecs[4] = '{sel: 2, perturb: 0, exp_done: 1'b0, exp_fail: 1'b1, mode: 3};

    reset = 1'b1; start_r = 1'b0; cur_sel = 0; ref_n = 0; lg_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en", bus0.wr_en, 0);
    check("rst_wr_row", bus0.wr_row, 0);
    check("rst_wr_col", bus0.wr_col, 0);
    check("rst_wr_data", bus0.wr_data, 0);
    check("rst_busy", bus0.busy, 0);
    check("rst_done", bus0.done, 0);
    check("rst_fail", bus0.fail, 0);
    check("rst_ships", bus0.ships_placed, 0);
    check("rst_lfsr", u_dut0.u_lfsr.q_q, 16'hACE1);
    check("rst_shadow", u_dut0.occ_q, 0);
    check("rst_attempts", u_dut0.attempts_q, 0);
    reset = 1'b0;

    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      run_game(vecs[v].sel, vecs[v].perturb, 1'b1, to);
      check({tag, "_timeout"}, to, 0);
      verify_game(tag, vecs[v].exp_done, vecs[v].exp_fail);
      case (vecs[v].mode)
        0: begin
          bad = 0;
          for (int i = 0; i < 100; i++)
            if (u_dut0.occ_q[i] != board[i]) bad++;
          check({tag, "_shadow_vs_board"}, bad, 0);
          ref_n = lg_n;
          for (int i = 0; i < 256; i++) begin
            ref_row[i] = lg_row[i]; ref_col[i] = lg_col[i]; ref_data[i] = lg_data[i];
          end
        end
        1: begin
          diff_ref(diff);
          check({tag, "_same_as_ref"}, diff, 0);
        end
        2: begin
          diff_ref(diff);
          check({tag, "_differs_from_ref"}, (diff != 0), 1);
        end
        default: ;
      endcase
    end

    // Reset during the third SHIP write, then a clean restart.
    run_game(0, 2, 1'b1, to);
    check("abort_reached", to, 0);
    @(posedge clk);
    #1;
    check("abort_wr_en", bus0.wr_en, 0);
    check("abort_wr_row", bus0.wr_row, 0);
    check("abort_wr_col", bus0.wr_col, 0);
    check("abort_wr_data", bus0.wr_data, 0);
    check("abort_busy", bus0.busy, 0);
    check("abort_done", bus0.done, 0);
    check("abort_fail", bus0.fail, 0);
    check("abort_ships", bus0.ships_placed, 0);
    check("abort_shadow", u_dut0.occ_q, 0);
    check("abort_lfsr", u_dut0.u_lfsr.q_q, 16'hACE1);
    @(posedge clk);
    #1;
    check("abort_wr_en_2", bus0.wr_en, 0);
    reset = 1'b0;
    run_game(0, 0, 1'b0, to);
    check("rerun_timeout", to, 0);
    verify_game("rerun", 1'b1, 1'b0);
    diff_ref(diff);
    check("rerun_same_as_ref", diff, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ship_placer.md
SHIP_PLACER -- requirements
Module: ship_placer

Interface
REQ-001 Parameter NUM_SHIPS, default 5, number of ships placed per game; lengths are 5,4,3,3,2 for indices 0..4.
REQ-002 Parameter MAX_ATTEMPTS, default 255, maximum placement attempts per game before failure.
REQ-003 Parameter LFSR_SEED, default 16'hACE1, LFSR value after reset; must be nonzero.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins a new board.
REQ-007 wr_en  out  1  board cell write strobe to game_state.
REQ-008 wr_row  out  4  target row, 0..9.
REQ-009 wr_col  out  4  target column, 0..9.
REQ-010 wr_data  out  2  cell code written.
REQ-011 busy  out  1  high from the cycle after an accepted start until DONE or FAIL.
REQ-012 done  out  1  level; all ships placed.
REQ-013 fail  out  1  level; attempt limit exhausted.
REQ-014 ships_placed  out  3  count of ships committed in the current game.

Function
REQ-015 States: IDLE, CLEAR, PICK, CHECK, WRITE, NEXT, DONE, FAIL.
REQ-016 start is accepted in IDLE, DONE or FAIL and moves to CLEAR, clearing done, fail, ships_placed, the attempt counter and the 100-bit occupancy shadow; start in any other state is ignored.
REQ-017 CLEAR: write EMPTY to cells (0,0)..(9,9), row-major, one per cycle, 100 cycles, then go to PICK.
REQ-018 A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) advances every cycle in every state.
REQ-019 PICK (one cycle): row=lfsr[3:0], col=lfsr[7:4], horizontal=lfsr[8]; increment attempts.
REQ-020 Reject the pick and stay in PICK if row>9, col>9, or the ship end (col+len-1 horizontal, row+len-1 vertical) exceeds 9.
REQ-021 Go to FAIL when attempts reaches MAX_ATTEMPTS and the current pick is rejected.
REQ-022 CHECK: test one candidate cell per cycle against the shadow; on the first occupied cell return to PICK, with no writes issued for that ship; after len clean cells go to WRITE.
REQ-023 WRITE: one SHIP write per cycle for len cycles, setting the matching shadow bit each cycle.
REQ-024 NEXT: increment ships_placed; go to DONE if it equals NUM_SHIPS, else to PICK.
REQ-025 wr_en, wr_row, wr_col and wr_data are registered, with a one-cycle latency from the state and cell index that produce them.
REQ-026 wr_en is low in IDLE, PICK, CHECK, NEXT, DONE and FAIL.
REQ-027 Ship cells never overlap and never leave the grid; the total number of SHIP writes per successful game is 17.
REQ-028 Cell indexing is linear, idx = row*10 + col, 7 bits wide; row and column increments never wrap past 9.
REQ-029 Attempts do not reset between ships; the budget covers the whole game.

Reset
REQ-030 Reset gives: state IDLE, LFSR=LFSR_SEED, shadow all 0, attempts 0, wr_en/wr_row/wr_col/wr_data 0, busy/done/fail 0, ships_placed 0.
REQ-031 Reset asserted mid-CLEAR or mid-WRITE aborts the operation; wr_en is low on the next cycle and no further writes occur.

Structure
REQ-032 A shared package holds: cell codes EMPTY=2'b00, SHIP=2'b01, MISS=2'b10, HIT=2'b11; GRID_DIM=10; the ship-length table; the state encoding.
REQ-033 The LFSR is a sub-module lfsr16 (clk, reset, seed, q); everything else is flat.

Verification
REQ-034 Reset, then start with default seed: exactly 100 EMPTY writes, then exactly 17 SHIP writes to distinct in-grid cells; done=1, ships_placed=5, fail=0, busy=0.
REQ-035 Run the same seed twice: both runs produce an identical write sequence; a different seed (16'h1234) produces a different board.
REQ-036 MAX_ATTEMPTS=5: fail=1 and done=0 within the bound; the last write before FAIL is a complete ship or an EMPTY write; no partial ship is written.
REQ-037 Pulse start during CLEAR cycle 50 and during WRITE: ignored; the write sequence is unchanged from the unperturbed run.
REQ-038 Assert reset during the third SHIP write: wr_en=0 next cycle; all REQ-030 values hold; a following start reruns the full sequence from CLEAR.
REQ-039 Compare the shadow against the game_state board after done: the boards are identical; every horizontal ship satisfies col+len-1≤9 and every vertical ship satisfies row+len-1≤9.
